midi_ctrl_regbank: RTL and testbench

- Clocked, parametrised successor to the patch-parameter store for oscillator, common and modulation-matrix data.
- Holds per-oscillator levels, modulation and feedback settings, pan, master volume, the patch name and two modulation matrices.
- Driven by the MIDI/sysex decoder through a synchronous strobe interface; no tristate bus.
- Adds a patch-dump sequencer that streams every bank address with a valid/ready handshake for sysex patch send.

---
 rtl/midi_ctrl_regbank.sv | 274 +++++++++++++++++++++++++++
 tb/tb_midi_ctrl_regbank.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/midi_ctrl_regbank.sv
// Patch-parameter register bank with a 1-cycle strobe read port and a valid/ready patch-dump sequencer.
// Optional change-notify outputs under MIDI_CTRL_CHANGE_NOTIFY_EN; dump words wait indefinitely on dump_ready.
module midi_ctrl_regbank #(
   parameter int V_OSC    = 4,
   parameter int M_ROWS   = 16,
   parameter int NAME_LEN = 16,
   parameter int DW       = 8,
   parameter int AW       = ($clog2(16*V_OSC) < 5) ? 5 : $clog2(16*V_OSC)
) (
   input  logic                                  sCLK_XVXENVS,
   input  logic                                  reset_data,
   input  logic [1:0]                            bank_sel,
   input  logic [AW-1:0]                         adr,
   input  logic                                  wr_en,
   input  logic [DW-1:0]                         wr_data,
   input  logic                                  rd_en,
   output logic [DW-1:0]                         rd_data,
   output logic                                  rd_valid,
   input  logic                                  dump_start,
   output logic                                  dump_busy,
   output logic [1:0]                            dump_bank,
   output logic [AW-1:0]                         dump_adr,
   output logic [DW-1:0]                         dump_data,
   output logic                                  dump_valid,
   input  logic                                  dump_ready,
   output logic                                  dump_done,
   output logic [V_OSC-1:0][DW-1:0]              osc_lvl,
   output logic [V_OSC-1:0][DW-1:0]              osc_mod,
   output logic [V_OSC-1:0][DW-1:0]              osc_feedb,
   output logic [V_OSC-1:0][DW-1:0]              osc_pan,
   output logic [V_OSC-1:0][DW-1:0]              osc_mod_in,
   output logic [V_OSC-1:0][DW-1:0]              osc_feedb_in,
   output logic [DW-1:0]                         m_vol,
   output logic [M_ROWS-1:0][V_OSC-1:0][DW-1:0]  mat_buf1,
   output logic [M_ROWS-1:0][V_OSC-1:0][DW-1:0]  mat_buf2,
   output logic [NAME_LEN-1:0][7:0]              patch_name
`ifdef MIDI_CTRL_CHANGE_NOTIFY_EN
   ,
   output logic                                  chg_valid,
   output logic [1:0]                            chg_bank,
   output logic [AW-1:0]                         chg_adr
`endif
);

   localparam int OW = AW - 4;
   localparam int RW = (M_ROWS > 1) ? $clog2(M_ROWS) : 1;
   localparam int NW = (NAME_LEN > 1) ? $clog2(NAME_LEN) : 1;
   localparam logic [AW-1:0] ADR_LAST = AW'(16*V_OSC - 1);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PRESENT, S_DONE} dump_state_t;

   logic [V_OSC-1:0][DW-1:0]             lvl_q, lvl_d, mod_q, mod_d, feedb_q, feedb_d;
   logic [V_OSC-1:0][DW-1:0]             pan_q, pan_d, mod_in_q, mod_in_d, feedb_in_q, feedb_in_d;
   logic [DW-1:0]                        vol_q, vol_d;
   logic [NAME_LEN-1:0][7:0]             name_q, name_d;
   logic [M_ROWS-1:0][V_OSC-1:0][DW-1:0] mat1_q, mat1_d, mat2_q, mat2_d;
   logic [DW-1:0]                        rd_data_q, rd_data_d;
   logic                                 rd_valid_q, rd_valid_d;
   dump_state_t                          state_q, state_d;
   logic [1:0]                           cbank_q, cbank_d;
   logic [AW-1:0]                        cadr_q, cadr_d;
   logic [DW-1:0]                        ddata_q, ddata_d;

   // Register decode shared by the host read port and the dump sequencer.
   function automatic logic [DW-1:0] reg_rd(input logic [1:0] b, input logic [AW-1:0] a);
      logic [DW-1:0] v;
      logic [OW-1:0] oi;
      logic [AW-1:0] ka;
      logic          o_ok;
      v    = '0;
      oi   = a[AW-1:4];
      ka   = a - AW'(16);
      o_ok = int'(a[AW-1:4]) < V_OSC;
      case (b)
         2'd0: if (o_ok) begin
            case (a[3:0])
               4'd2:    v = lvl_q[oi];
               4'd3:    v = mod_q[oi];
               4'd4:    v = feedb_q[oi];
               4'd7:    v = pan_q[oi];
               4'd10:   v = mod_in_q[oi];
               4'd11:   v = feedb_in_q[oi];
               default: v = '0;
            endcase
         end
         2'd1: begin
            if (a == AW'(1)) v = vol_q;
            else if (a >= AW'(16) && int'(a) < 16 + NAME_LEN) v = DW'(name_q[ka[NW-1:0]]);
         end
         2'd2: if (o_ok && int'(a[3:0]) < M_ROWS) v = mat1_q[a[RW-1:0]][oi];
         default: if (o_ok && int'(a[3:0]) < M_ROWS) v = mat2_q[a[RW-1:0]][oi];
      endcase
      return v;
   endfunction

   logic [OW-1:0] wr_oi;
   logic [AW-1:0] wr_ka;
   logic          wr_osc_ok, wr_row_ok, wr_name_ok;
   assign wr_oi      = adr[AW-1:4];
   assign wr_ka      = adr - AW'(16);
   assign wr_osc_ok  = int'(adr[AW-1:4]) < V_OSC;
   assign wr_row_ok  = wr_osc_ok && (int'(adr[3:0]) < M_ROWS);
   assign wr_name_ok = (adr >= AW'(16)) && (int'(adr) < 16 + NAME_LEN);

   always_comb begin
      lvl_d      = lvl_q;
      mod_d      = mod_q;
      feedb_d    = feedb_q;
      pan_d      = pan_q;
      mod_in_d   = mod_in_q;
      feedb_in_d = feedb_in_q;
      vol_d      = vol_q;
      name_d     = name_q;
      mat1_d     = mat1_q;
      mat2_d     = mat2_q;
      if (wr_en) begin
         case (bank_sel)
            2'd0: if (wr_osc_ok) begin
               case (adr[3:0])
                  4'd2:    lvl_d[wr_oi]      = wr_data;
                  4'd3:    mod_d[wr_oi]      = wr_data;
                  4'd4:    feedb_d[wr_oi]    = wr_data;
                  4'd7:    pan_d[wr_oi]      = wr_data;
                  4'd10:   mod_in_d[wr_oi]   = wr_data;
                  4'd11:   feedb_in_d[wr_oi] = wr_data;
                  default: ;
               endcase
            end
            2'd1: begin
               if (adr == AW'(1)) vol_d = wr_data;
               else if (wr_name_ok) name_d[wr_ka[NW-1:0]] = wr_data[7:0];
            end
            2'd2: if (wr_row_ok) mat1_d[adr[RW-1:0]][wr_oi] = wr_data;
            default: if (wr_row_ok) mat2_d[adr[RW-1:0]][wr_oi] = wr_data;
         endcase
      end
   end

   // Reads sample the pre-write contents, so a colliding write is seen one cycle later.
   always_comb begin
      rd_valid_d = rd_en;
      rd_data_d  = rd_en ? reg_rd(bank_sel, adr) : rd_data_q;
   end

   always_comb begin
      state_d = state_q;
      cbank_d = cbank_q;
      cadr_d  = cadr_q;
      ddata_d = ddata_q;
      case (state_q)
         S_IDLE: if (dump_start) begin
            state_d = S_LOAD;
            cbank_d = 2'd0;
            cadr_d  = '0;
         end
         S_LOAD: begin
            ddata_d = reg_rd(cbank_q, cadr_q);
            state_d = S_PRESENT;
         end
         S_PRESENT: if (dump_ready) begin
            if (cbank_q == 2'd3 && cadr_q == ADR_LAST) begin
               state_d = S_DONE;
            end else begin
               state_d = S_LOAD;
               if (cadr_q == ADR_LAST) begin
                  cadr_d  = '0;
                  cbank_d = cbank_q + 2'd1;
               end else begin
                  cadr_d = cadr_q + AW'(1);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

`ifdef MIDI_CTRL_CHANGE_NOTIFY_EN
   function automatic logic addr_hit(input logic [1:0] b, input logic [AW-1:0] a);
      logic o_ok;
      o_ok = int'(a[AW-1:4]) < V_OSC;
      case (b)
         2'd0:    return o_ok && (a[3:0] inside {4'd2, 4'd3, 4'd4, 4'd7, 4'd10, 4'd11});
         2'd1:    return (a == AW'(1)) || ((a >= AW'(16)) && (int'(a) < 16 + NAME_LEN));
         default: return o_ok && (int'(a[3:0]) < M_ROWS);
      endcase
   endfunction

   logic          chg_valid_q, chg_valid_d;
   logic [1:0]    chg_bank_q, chg_bank_d;
   logic [AW-1:0] chg_adr_q, chg_adr_d;

   always_comb begin
      chg_valid_d = wr_en && addr_hit(bank_sel, adr) && (reg_rd(bank_sel, adr) != wr_data);
      chg_bank_d  = chg_valid_d ? bank_sel : chg_bank_q;
      chg_adr_d   = chg_valid_d ? adr : chg_adr_q;
   end

   always_ff @(posedge sCLK_XVXENVS) begin
      if (reset_data) begin
         chg_valid_q <= 1'b0;
         chg_bank_q  <= 2'd0;
         chg_adr_q   <= '0;
      end else begin
         chg_valid_q <= chg_valid_d;
         chg_bank_q  <= chg_bank_d;
         chg_adr_q   <= chg_adr_d;
      end
   end

   assign chg_valid = chg_valid_q;
   assign chg_bank  = chg_bank_q;
   assign chg_adr   = chg_adr_q;
`endif

   always_ff @(posedge sCLK_XVXENVS) begin
      if (reset_data) begin
         for (int o = 0; o < V_OSC; o++) begin
            lvl_q[o]      <= (o < 2) ? DW'(8'h40) : '0;
            mod_q[o]      <= '0;
            feedb_q[o]    <= '0;
            pan_q[o]      <= DW'(8'h40);
            mod_in_q[o]   <= '0;
            feedb_in_q[o] <= '0;
         end
         for (int k = 0; k < NAME_LEN; k++) name_q[k] <= 8'h20;
         vol_q      <= DW'(8'h40);
         mat1_q     <= '0;
         mat2_q     <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         state_q    <= S_IDLE;
         cbank_q    <= 2'd0;
         cadr_q     <= '0;
         ddata_q    <= '0;
      end else begin
         lvl_q      <= lvl_d;
         mod_q      <= mod_d;
         feedb_q    <= feedb_d;
         pan_q      <= pan_d;
         mod_in_q   <= mod_in_d;
         feedb_in_q <= feedb_in_d;
         name_q     <= name_d;
         vol_q      <= vol_d;
         mat1_q     <= mat1_d;
         mat2_q     <= mat2_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         state_q    <= state_d;
         cbank_q    <= cbank_d;
         cadr_q     <= cadr_d;
         ddata_q    <= ddata_d;
      end
   end

   assign rd_data      = rd_data_q;
   assign rd_valid     = rd_valid_q;
   assign dump_busy    = (state_q == S_LOAD) || (state_q == S_PRESENT);
   assign dump_valid   = (state_q == S_PRESENT);
   assign dump_done    = (state_q == S_DONE);
   assign dump_bank    = cbank_q;
   assign dump_adr     = cadr_q;
   assign dump_data    = ddata_q;
   assign osc_lvl      = lvl_q;
   assign osc_mod      = mod_q;
   assign osc_feedb    = feedb_q;
   assign osc_pan      = pan_q;
   assign osc_mod_in   = mod_in_q;
   assign osc_feedb_in = feedb_in_q;
   assign m_vol        = vol_q;
   assign mat_buf1     = mat1_q;
   assign mat_buf2     = mat2_q;
   assign patch_name   = name_q;

endmodule

// File: tb/tb_midi_ctrl_regbank.sv
// Randomised bench for midi_ctrl_regbank: flat per-bank byte-array model, scoreboard queues, negedge monitor.
module tb_midi_ctrl_regbank;

   localparam int V  = 4;
   localparam int MR = 16;
   localparam int NL = 16;
   localparam int DW = 8;
   localparam int AW = 6;
   localparam int NA = 16 * V;

   localparam int CK_REGS = 0, CK_IDLE = 1, CK_DONE = 2, CK_HS = 3, CK_DQ = 4, CK_RQ = 5, CK_TMO = 6, CK_RDV = 7;

   typedef struct {int kind; int exp;} ck_t;

   logic                       clk = 1'b0;
   logic                       reset_data, wr_en, rd_en, dump_start, dump_ready;
   logic [1:0]                 bank_sel;
   logic [AW-1:0]              adr;
   logic [DW-1:0]              wr_data;
   logic [DW-1:0]              rd_data, dump_data, m_vol;
   logic                       rd_valid, dump_busy, dump_valid, dump_done;
   logic [1:0]                 dump_bank;
   logic [AW-1:0]              dump_adr;
   logic [V-1:0][DW-1:0]       osc_lvl, osc_mod, osc_feedb, osc_pan, osc_mod_in, osc_feedb_in;
   logic [MR-1:0][V-1:0][DW-1:0] mat_buf1, mat_buf2;
   logic [NL-1:0][7:0]         patch_name;

   always #5 clk = ~clk;

   midi_ctrl_regbank dut (
      .sCLK_XVXENVS(clk), .reset_data(reset_data), .bank_sel(bank_sel), .adr(adr),
      .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
      .dump_start(dump_start), .dump_busy(dump_busy), .dump_bank(dump_bank), .dump_adr(dump_adr),
      .dump_data(dump_data), .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_done(dump_done),
      .osc_lvl(osc_lvl), .osc_mod(osc_mod), .osc_feedb(osc_feedb), .osc_pan(osc_pan),
      .osc_mod_in(osc_mod_in), .osc_feedb_in(osc_feedb_in), .m_vol(m_vol),
      .mat_buf1(mat_buf1), .mat_buf2(mat_buf2), .patch_name(patch_name)
   );

   // Reference model: one byte per bank address, filled only at mapped locations.
   logic [7:0]  model [4][NA];
   logic [7:0]  rexp [$];
   logic [15:0] dexp [$];
   ck_t         chkq [$];
   int          n_cmp = 0, n_err = 0, hs_cnt = 0, done_cnt = 0;
   bit          mon_en = 0;

   function automatic bit mapped(int b, int a);
      case (b)
         0:       return (a / 16 < V) && ((a % 16) inside {2, 3, 4, 7, 10, 11});
         1:       return (a == 1) || (a >= 16 && a < 16 + NL);
         default: return (a / 16 < V) && (a % 16 < MR);
      endcase
   endfunction

   function automatic logic [7:0] mread(int b, int a);
      return mapped(b, a) ? model[b][a] : 8'h00;
   endfunction

   task automatic model_reset();
      for (int b = 0; b < 4; b++) for (int a = 0; a < NA; a++) model[b][a] = 8'h00;
      for (int o = 0; o < V; o++) begin
         model[0][o*16+2] = (o < 2) ? 8'h40 : 8'h00;
         model[0][o*16+7] = 8'h40;
      end
      model[1][1] = 8'h40;
      for (int k = 0; k < NL; k++) model[1][16+k] = 8'h20;
   endtask

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (rd_valid) begin
            if (rexp.size() == 0) cmp("rd_valid_unexpected", 1, 0);
            else cmp("rd_data", rd_data, rexp.pop_front());
         end
         if (dump_valid && dump_ready) begin
            hs_cnt++;
            if (dexp.size() == 0) cmp("dump_word_unexpected", {dump_bank, dump_adr, dump_data}, 0);
            else cmp("dump_word", {dump_bank, dump_adr, dump_data}, dexp.pop_front());
         end
         if (dump_done) done_cnt++;
         while (chkq.size() > 0) begin
            ck_t c;
            c = chkq.pop_front();
            case (c.kind)
               CK_REGS: begin
                  for (int o = 0; o < V; o++) begin
                     cmp("osc_lvl", osc_lvl[o], model[0][o*16+2]);
                     cmp("osc_mod", osc_mod[o], model[0][o*16+3]);
                     cmp("osc_feedb", osc_feedb[o], model[0][o*16+4]);
                     cmp("osc_pan", osc_pan[o], model[0][o*16+7]);
                     cmp("osc_mod_in", osc_mod_in[o], model[0][o*16+10]);
                     cmp("osc_feedb_in", osc_feedb_in[o], model[0][o*16+11]);
                     for (int r = 0; r < MR; r++) begin
                        cmp("mat_buf1", mat_buf1[r][o], model[2][o*16+r]);
                        cmp("mat_buf2", mat_buf2[r][o], model[3][o*16+r]);
                     end
                  end
                  cmp("m_vol", m_vol, model[1][1]);
                  for (int k = 0; k < NL; k++) cmp("patch_name", patch_name[k], model[1][16+k]);
               end
               CK_IDLE: begin
                  cmp("dump_busy_idle", dump_busy, 0);
                  cmp("dump_valid_idle", dump_valid, 0);
               end
               CK_DONE: cmp("dump_done_count", done_cnt, c.exp);
               CK_HS:   cmp("dump_word_count", hs_cnt, c.exp);
               CK_DQ:   cmp("dump_words_missing", dexp.size(), 0);
               CK_RQ:   cmp("reads_missing", rexp.size(), 0);
               CK_RDV:  cmp("rd_valid_reset", rd_valid, 0);
               default: cmp("dump_timeout", 1, 0);
            endcase
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic req(input int kind, input int exp);
      ck_t c;
      c.kind = kind;
      c.exp  = exp;
      chkq.push_back(c);
      tick();
   endtask

   // One host cycle; the expected read value is taken before the same-cycle write lands.
   task automatic op(input int b, input int a, input bit we, input logic [7:0] wd, input bit re);
      bank_sel = b[1:0];
      adr      = a[AW-1:0];
      wr_en    = we;
      wr_data  = wd;
      rd_en    = re;
      if (re) rexp.push_back(mread(b, a));
      if (we && mapped(b, a)) model[b][a] = wd;
      tick();
      wr_en = 1'b0;
      rd_en = 1'b0;
   endtask

   task automatic start_dump();
      for (int b = 0; b < 4; b++)
         for (int a = 0; a < NA; a++)
            dexp.push_back({b[1:0], a[AW-1:0], mread(b, a)});
      dump_start = 1'b1;
      tick();
      dump_start = 1'b0;
   endtask

   initial begin
      int base_hs, base_done;
      reset_data = 1'b1; wr_en = 0; rd_en = 0; dump_start = 0; dump_ready = 0;
      bank_sel = '0; adr = '0; wr_data = '0;
      repeat (2) @(posedge clk);
      #1;
      reset_data = 1'b0;
      model_reset();
      mon_en = 1'b1;
      req(CK_REGS, 0);
      req(CK_IDLE, 0);
      req(CK_RDV, 0);

      op(0, 'h13, 1, 8'h55, 0);
      op(0, 'h13, 0, 8'h00, 1);
      tick();
      req(CK_REGS, 0);

      op(1, 5, 1, 8'h7F, 0);
      op(1, 5, 0, 8'h00, 1);
      op(0, 'h0C, 0, 8'h00, 1);
      op(3, 'h3A, 1, 8'h11, 0);
      tick();
      req(CK_REGS, 0);

      op(0, 2, 1, 8'h99, 1);
      op(0, 2, 0, 8'h00, 1);

      for (int i = 0; i < 400; i++)
         op($urandom_range(0, 3), $urandom_range(0, NA - 1), 1'($urandom_range(0, 1)),
            8'($urandom), 1'($urandom_range(0, 1)));
      repeat (2) tick();
      req(CK_REGS, 0);
      req(CK_RQ, 0);

      op(1, 16, 1, 8'h41, 0);
      base_hs   = hs_cnt;
      base_done = done_cnt;
      start_dump();
      for (int i = 0; i < 5000 && done_cnt == base_done; i++) begin
         dump_ready = 1'($urandom_range(0, 1));
         tick();
      end
      dump_ready = 1'b0;
      if (done_cnt == base_done) req(CK_TMO, 0);
      repeat (3) tick();
      req(CK_DONE, base_done + 1);
      req(CK_HS, base_hs + 4 * NA);
      req(CK_IDLE, 0);
      req(CK_DQ, 0);

      base_hs   = hs_cnt;
      base_done = done_cnt;
      start_dump();
      for (int i = 0; i < 3000 && hs_cnt < base_hs + 100; i++) begin
         dump_ready = 1'($urandom_range(0, 1));
         tick();
      end
      dump_ready = 1'b0;
      if (hs_cnt < base_hs + 100) req(CK_TMO, 0);
      reset_data = 1'b1;
      tick();
      reset_data = 1'b0;
      dexp.delete();
      model_reset();
      repeat (20) tick();
      req(CK_DONE, base_done);
      req(CK_HS, base_hs + 100);
      req(CK_IDLE, 0);
      req(CK_REGS, 0);

      repeat (2) tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
